ft60x_fifo_emu: RTL
===================

Name: ft60x_fifo_emu

Overview:
- Synthesizable emulator of the FTDI FT600/FT601 device side in 245 synchronous-FIFO mode.
- It is the responder that our FPGA FIFO master talks to: it drives TXE_N, RXF_N and read data, and it accepts OE_N, RD_N, WR_N and write data.
- A host-side stream port injects "USB host → FPGA" words and drains "FPGA → USB host" words.
- Used in on-chip loopback and in benches, so no physical FT60x is needed.

Parameters:
- D_BIT, 16, bus data width (32 for FT601).
- BE_BIT, 2, byte-enable width (D_BIT/8).
- RX_DEPTH, 16, host→FPGA FIFO depth in words; power of 2, ≥4.
- TX_DEPTH, 16, FPGA→host FIFO depth in words; power of 2, ≥4.

Ports:
- iCLK  in  1  USB-side clock; all logic on the rising edge.
- iRST_N  in  1  synchronous active-low reset.
- iOE_N  in  1  master output enable, active low.
- iRD_N  in  1  master read strobe, active low.
- iWR_N  in  1  master write strobe, active low.
- iDATA  in  D_BIT  write data from master.
- iBE  in  BE_BIT  write byte enables from master.
- oDATA  out  D_BIT  read data to master.
- oBE  out  BE_BIT  read byte enables to master.
- oDATA_OE  out  1  high = emulator drives the DATA/BE bus; the top level builds the tristate.
- oTXE_N  out  1  low = emulator can accept writes.
- oRXF_N  out  1  low = emulator has read data.
- iRXF_HOLD  in  1  force oRXF_N high (backpressure injection).
- iTXE_HOLD  in  1  force oTXE_N high.
- iHOST_DATA  in  D_BIT  injected host→FPGA word.
- iHOST_BE  in  BE_BIT  its byte enables.
- iHOST_VALID  in  1  push request.
- oHOST_READY  out  1  RX FIFO not full.
- oTX_DATA  out  D_BIT  head of the FPGA→host FIFO.
- oTX_BE  out  BE_BIT  head byte enables.
- oTX_VALID  out  1  TX FIFO not empty.
- iTX_READY  in  1  pop request.
- oRX_CNT  out  16  words delivered to master; wraps.
- oTX_CNT  out  16  words accepted from master; wraps.
- oERR  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values:
  - oRXF_N=1, oTXE_N=1, oDATA_OE=0, oDATA=0, oBE=0.
  - Both FIFOs empty, counters 0, oERR=0.
  - oTXE_N drops to 0 on the first cycle after reset release.
- Reset mid-transfer: all FIFO contents are discarded and the bus is released on the same edge.
- Host push:
  - A word is stored when iHOST_VALID & oHOST_READY.
  - oHOST_READY = (rx_count < RX_DEPTH), derived from the registered count.
- RX read (master reads):
  - oRXF_N <= (rx_count_next == 0) | iRXF_HOLD.
  - oDATA_OE <= ~iOE_N, so the bus is driven one cycle after OE_N falls and released one cycle after OE_N rises.
  - oDATA/oBE are registered: they always hold the FIFO head after this cycle's pop, or 0 when empty.
  - Pop condition: ~iOE_N & ~iRD_N & ~oRXF_N. This pops one word per cycle and increments oRX_CNT.
  - When the last word pops, oRXF_N rises on the same edge, so no under-read is possible.
- TX write (master writes):
  - Push condition: ~iWR_N & ~oTXE_N. This stores iDATA/iBE and increments oTX_CNT.
  - oTXE_N <= (tx_count_next == TX_DEPTH) | iTXE_HOLD.
  - The write that fills the FIFO raises oTXE_N on the same edge, so there is no overflow.
- Host drain: oTX_VALID = tx_count != 0. Pop occurs on oTX_VALID & iTX_READY.
- Simultaneous push and pop on either FIFO: the count is unchanged and both operations take effect. A pop on a full FIFO frees space on the same edge.
- Pointers wrap modulo depth. Counts are log2(DEPTH)+1 bits wide.
- oERR sets (sticky until reset) when any of these occurs:
  - iRD_N=0 while iOE_N=1;
  - iWR_N=0 and iOE_N=0 together;
  - iWR_N=0 while oTXE_N=1 (the word is discarded and not counted);
  - iRD_N=0 while oRXF_N=1 (no pop).
- oDATA_OE is forced to 0 whenever iWR_N=0, which avoids bus contention.

Decomposition:
- defines.v gains:
  - FT_D_BIT and FT_BE_BIT defaults;
  - FT_FIFO_DEPTH_LOG2;
  - the error-cause bit positions for a future status register.
- One sub-module, usb_sync_fifo: a parameterized synchronous FIFO with width D_BIT+BE_BIT, push/pop, full/empty and count. It is instantiated twice (RX and TX).

Test Plan:
- Reset release: check oTXE_N=0 and oRXF_N=1 after one cycle; oDATA_OE=0; counters=0.
- Read with backpressure: push 3 words 0x1111, 0x2222, 0x3333 (BE=2'b11) via host; master sets OE_N=0 and RD_N=0 one cycle later → oDATA_OE rises next cycle, data arrives in order, oRXF_N=1 after the third pop, oRX_CNT=3, oERR=0.
- Write and drain: master writes 16 words 0x0000..0x000F while iTX_READY=0 → oTXE_N=1 after the 16th; a 17th WR_N=0 cycle sets oERR and oTX_CNT stays 16; draining yields 0x0000..0x000F in order.
- Full-boundary simultaneous push/pop: hold iTX_READY=1 with TX_DEPTH-1 words stored while the master writes continuously → oTXE_N stays 0 and no word is lost.
- Hold pins: iRXF_HOLD=1 with data present → oRXF_N=1; RD_N=0 sets oERR with no pop; release → normal read resumes.
- Mid-burst reset: iRST_N=0 during a 5-word read → next cycle oDATA_OE=0, oRXF_N=1, FIFO empty, counters 0.

Source files
------------

// File: rtl/ft60x_fifo_emu_pkg.sv
// Shared constants for the FT60x 245-mode FIFO emulator.
package ft60x_fifo_emu_pkg;

  localparam int FT_D_BIT           = 16;
  localparam int FT_BE_BIT          = FT_D_BIT / 8;
  localparam int FT_FIFO_DEPTH_LOG2 = 4;

  // Bit positions of the individual protocol-violation causes; kept stable
  // so a future status register can expose them directly.
  localparam int ERR_BIT_RD_NO_OE   = 0;  // RD_N low while OE_N high
  localparam int ERR_BIT_WR_WITH_OE = 1;  // WR_N and OE_N low together
  localparam int ERR_BIT_WR_NO_TXE  = 2;  // write attempted while TXE_N high
  localparam int ERR_BIT_RD_NO_RXF  = 3;  // read attempted while RXF_N high
  localparam int ERR_CAUSES         = 4;

endpackage

// File: rtl/ft60x_fifo_emu_if.sv
// FT60x synchronous FIFO bus as seen between the FPGA master and the emulator.
interface ft60x_fifo_emu_if
  import ft60x_fifo_emu_pkg::*;
#(
  parameter int D_BIT  = FT_D_BIT,
  parameter int BE_BIT = FT_BE_BIT
);

  logic              iOE_N;
  logic              iRD_N;
  logic              iWR_N;
  logic [D_BIT-1:0]  iDATA;
  logic [BE_BIT-1:0] iBE;
  logic [D_BIT-1:0]  oDATA;
  logic [BE_BIT-1:0] oBE;
  logic              oDATA_OE;
  logic              oTXE_N;
  logic              oRXF_N;

  modport master (
    output iOE_N, iRD_N, iWR_N, iDATA, iBE,
    input  oDATA, oBE, oDATA_OE, oTXE_N, oRXF_N
  );

  modport slave (
    input  iOE_N, iRD_N, iWR_N, iDATA, iBE,
    output oDATA, oBE, oDATA_OE, oTXE_N, oRXF_N
  );

endinterface

// File: rtl/ft60x_fifo_emu_usb_sync_fifo.sv
// Synchronous FIFO that also exposes the head word as it will be after
// this cycle's push/pop, so the owner can register it as a zero-latency head.
module usb_sync_fifo
  import ft60x_fifo_emu_pkg::*;
#(
  parameter int W     = FT_D_BIT + FT_BE_BIT,
  parameter int DEPTH = 2 ** FT_FIFO_DEPTH_LOG2
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   push,
  input  logic [W-1:0]           pushData,
  input  logic                   pop,
  output logic [W-1:0]           headNext,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] countNext
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtrNext;
  logic [PW:0]   remain;
  logic          doPush;
  logic          doPop;

  assign doPush    = push & (count != (PW+1)'(DEPTH));
  assign doPop     = pop & (count != '0);
  assign countNext = count + (PW+1)'(doPush) - (PW+1)'(doPop);
  assign remain    = count - (PW+1)'(doPop);
  assign rdPtrNext = rdPtr + PW'(doPop);

  // Head after this edge: surviving old word, else the word being pushed, else zero.
  always_comb begin
    headNext = '0;
    if (remain != '0)
      headNext = mem[rdPtrNext];
    else if (doPush)
      headNext = pushData;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      rdPtr <= rdPtrNext;
      wrPtr <= wrPtr + PW'(doPush);
      count <= countNext;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/ft60x_fifo_emu.sv
// Device-side emulator of an FT600/FT601 in 245 synchronous-FIFO mode.
module ft60x_fifo_emu
  import ft60x_fifo_emu_pkg::*;
#(
  parameter int D_BIT    = FT_D_BIT,
  parameter int BE_BIT   = FT_BE_BIT,
  parameter int RX_DEPTH = 2 ** FT_FIFO_DEPTH_LOG2,
  parameter int TX_DEPTH = 2 ** FT_FIFO_DEPTH_LOG2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  ft60x_fifo_emu_if.slave   bus,
  input  logic              iRXF_HOLD,
  input  logic              iTXE_HOLD,
  input  logic [D_BIT-1:0]  iHOST_DATA,
  input  logic [BE_BIT-1:0] iHOST_BE,
  input  logic              iHOST_VALID,
  output logic              oHOST_READY,
  output logic [D_BIT-1:0]  oTX_DATA,
  output logic [BE_BIT-1:0] oTX_BE,
  output logic              oTX_VALID,
  input  logic              iTX_READY,
  output logic [15:0]       oRX_CNT,
  output logic [15:0]       oTX_CNT,
  output logic              oERR
);

  localparam int W   = D_BIT + BE_BIT;
  localparam int RXW = $clog2(RX_DEPTH) + 1;
  localparam int TXW = $clog2(TX_DEPTH) + 1;

  logic [W-1:0]          rxHeadNext;
  logic [W-1:0]          txHeadNext;
  logic [RXW-1:0]        rxCount;
  logic [RXW-1:0]        rxCountNext;
  logic [TXW-1:0]        txCount;
  logic [TXW-1:0]        txCountNext;
  logic                  rxPop;
  logic                  txPush;
  logic                  oeReg;
  logic [ERR_CAUSES-1:0] errCause;

  assign rxPop       = ~bus.iOE_N & ~bus.iRD_N & ~bus.oRXF_N;
  assign txPush      = ~bus.iWR_N & ~bus.oTXE_N;
  assign oHOST_READY = rxCount < RXW'(RX_DEPTH);
  assign oTX_VALID   = txCount != '0;
  // Never drive the shared bus while the master is writing.
  assign bus.oDATA_OE = oeReg & bus.iWR_N;

  // Flag every bus-protocol violation by cause.
  always_comb begin
    errCause                     = '0;
    errCause[ERR_BIT_RD_NO_OE]   = ~bus.iRD_N & bus.iOE_N;
    errCause[ERR_BIT_WR_WITH_OE] = ~bus.iWR_N & ~bus.iOE_N;
    errCause[ERR_BIT_WR_NO_TXE]  = ~bus.iWR_N & bus.oTXE_N;
    errCause[ERR_BIT_RD_NO_RXF]  = ~bus.iRD_N & bus.oRXF_N;
  end

  usb_sync_fifo #(.W(W), .DEPTH(RX_DEPTH)) rxFifo (
    .clk       (iCLK),
    .rstN      (iRST_N),
    .push      (iHOST_VALID),
    .pushData  ({iHOST_DATA, iHOST_BE}),
    .pop       (rxPop),
    .headNext  (rxHeadNext),
    .count     (rxCount),
    .countNext (rxCountNext)
  );

  usb_sync_fifo #(.W(W), .DEPTH(TX_DEPTH)) txFifo (
    .clk       (iCLK),
    .rstN      (iRST_N),
    .push      (txPush),
    .pushData  ({bus.iDATA, bus.iBE}),
    .pop       (iTX_READY),
    .headNext  (txHeadNext),
    .count     (txCount),
    .countNext (txCountNext)
  );

  // Registered bus flags, read head, host-side TX head, counters and sticky error.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      bus.oRXF_N         <= 1'b1;
      bus.oTXE_N         <= 1'b1;
      oeReg              <= 1'b0;
      {bus.oDATA, bus.oBE} <= '0;
      {oTX_DATA, oTX_BE} <= '0;
      oRX_CNT            <= '0;
      oTX_CNT            <= '0;
      oERR               <= 1'b0;
    end else begin
      bus.oRXF_N         <= (rxCountNext == '0) | iRXF_HOLD;
      bus.oTXE_N         <= (txCountNext == TXW'(TX_DEPTH)) | iTXE_HOLD;
      oeReg              <= ~bus.iOE_N;
      {bus.oDATA, bus.oBE} <= rxHeadNext;
      {oTX_DATA, oTX_BE} <= txHeadNext;
      oRX_CNT            <= oRX_CNT + 16'(rxPop);
      oTX_CNT            <= oTX_CNT + 16'(txPush);
      oERR               <= oERR | (|errCause);
    end
  end

endmodule
